// File: rtl/branch_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding imem requests, buffers words for decode.
// Latency: req at t, 1-cycle mem resp at t+1, instr_valid at t+2; redirect re-targets fetch next cycle.
// Backpressure: fetch stalls while the FIFO is full; imem responses are never back-pressured.
module branch_fetch_unit #(
    parameter int                XLEN      = 64,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc,
    output logic            misalign
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     buf_data_q [BUF_DEPTH];
    logic [31:0]     buf_data_d [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_q   [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_d   [BUF_DEPTH];

    logic req_fire;
    logic push;
    logic pop;

    // Only one request is ever in flight, so a free slot at issue time is a free slot at response time.
    assign imem_req_valid = !rst && (state_q == S_REQ) && !redirect_valid
                            && (count_q < CW'(BUF_DEPTH));
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign misalign       = misalign_q;

    assign instr_valid    = !rst && (count_q != '0);
    assign instr_data     = buf_data_q[rd_ptr_q];
    assign instr_pc       = buf_pc_q[rd_ptr_q];

    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_resp_valid && (state_q == S_WAIT) && !redirect_valid;
    assign pop            = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    pc_d     = pc_q + XLEN'(4);
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The stale response retires the outstanding request even if another redirect lands with it.
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (push) begin
            buf_data_d[wr_ptr_q] = imem_resp_data;
            buf_pc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (redirect_valid) begin
            pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage needs no reset: count_q qualifies every read.
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
        buf_pc_q   <= buf_pc_d;
    end

endmodule
